// File: rtl/uart_boot_loader_ctrl.sv
// Assembles little-endian UART bytes into 32-bit words and writes them to instruction memory, holding the core in reset until a full image is loaded.
// Each write strobe appears the cycle after a word's 4th byte. There is no backpressure: every byte is taken, except while in DONE or when it coincides with a BREAK.
module uart_boot_loader_ctrl #(
  parameter int WORDS       = 32,
  parameter int AW          = 5,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          uart_rx_valid,
  input  logic [7:0]    uart_rx_data,
  input  logic          uart_rx_break,
  output logic          uart_rx_en,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_resetn,
  output logic          write_done,
  output logic          load_error
);

  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   word_q, word_d;
  logic          rx_en_q, rx_en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          cpu_resetn_q, cpu_resetn_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = tmo_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;

    case (state_q)
      IDLE: state_d = LOAD;

      LOAD: begin
        if (uart_rx_break) begin
          byte_cnt_d = 2'd0;
          word_cnt_d = '0;
          tmo_d      = '0;
          err_d      = 1'b1;
        end else if (uart_rx_valid) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = uart_rx_data;
          tmo_d = '0;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            state_d    = COMMIT;
            addr_d     = word_cnt_q;
            wdata_d    = word_d;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (byte_cnt_q == 2'd0) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
          // Sender stalled mid-word: drop the partial word, keep the address.
          byte_cnt_d = 2'd0;
          tmo_d      = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      COMMIT: begin
        if (uart_rx_break) begin
          state_d    = LOAD;
          byte_cnt_d = 2'd0;
          word_cnt_d = '0;
          tmo_d      = '0;
          err_d      = 1'b1;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_ADDR) begin
            state_d = DONE;
            err_d   = 1'b0;
          end else begin
            state_d = LOAD;
            // A byte landing during the write cycle opens the next word.
            if (uart_rx_valid) begin
              word_d[7:0] = uart_rx_data;
              byte_cnt_d  = 2'd1;
              tmo_d       = '0;
            end
          end
        end
      end

      DONE: begin
        if (uart_rx_break) begin
          state_d    = LOAD;
          byte_cnt_d = 2'd0;
          word_cnt_d = '0;
          tmo_d      = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    rx_en_d      = (state_d != IDLE);
    we_d         = (state_d == COMMIT);
    cpu_resetn_d = (state_d == DONE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 2'd0;
      word_cnt_q   <= '0;
      tmo_q        <= '0;
      word_q       <= '0;
      rx_en_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_resetn_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      tmo_q        <= tmo_d;
      word_q       <= word_d;
      rx_en_q      <= rx_en_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_resetn_q <= cpu_resetn_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign uart_rx_en = rx_en_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_resetn = cpu_resetn_q;
  assign write_done = done_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Bench for uart_boot_loader_ctrl: randomized byte streams checked against an image-level model.
module tb_uart_boot_loader_ctrl;

  localparam int WORDS = 2;
  localparam int AW    = 2;
  localparam int TMO   = 100;
  localparam int NB    = 4 * WORDS;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          uart_rx_valid = 1'b0;
  logic [7:0]    uart_rx_data = 8'h00;
  logic          uart_rx_break = 1'b0;
  logic          uart_rx_en;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_resetn;
  logic          write_done;
  logic          load_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] wr_a[$];
  logic [31:0]   wr_d[$];

  always #5 clk = ~clk;

  uart_boot_loader_ctrl #(.WORDS(WORDS), .AW(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_break(uart_rx_break),
    .uart_rx_en(uart_rx_en), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_resetn(cpu_resetn), .write_done(write_done), .load_error(load_error)
  );

  // Every cycle with a write strobe is one memory write.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_a.push_back(imem_addr);
      wr_d.push_back(imem_wdata);
    end
  end

  function automatic logic [31:0] word_of(input bq_t b, input int i);
    return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
  endfunction

  task automatic gen_image(output bq_t b);
    b = {};
    for (int i = 0; i < NB; i++) b.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic brk);
    uart_rx_valid = v;
    uart_rx_data  = d;
    uart_rx_break = brk;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
    uart_rx_break = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_bytes(input bq_t b, input int from, input int to, input int maxgap);
    for (int i = from; i < to; i++) begin
      cyc(1'b1, b[i], 1'b0);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_break = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({uart_rx_en, imem_we, imem_addr, imem_wdata, cpu_resetn, write_done, load_error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got en=%b we=%b a=%h d=%h cpu=%b done=%b err=%b want all 0",
               uart_rx_en, imem_we, imem_addr, imem_wdata, cpu_resetn, write_done, load_error);
    end
    resetn = 1'b1;
    #1;
    n_checks++;
    if (uart_rx_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_rx_en got %b want 0", uart_rx_en);
    end
    @(posedge clk); #1;
    n_checks++;
    if (uart_rx_en !== 1'b1 || cpu_resetn !== 1'b0 || write_done !== 1'b0 || imem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL load_entry got en=%b cpu=%b done=%b we=%b want 1 0 0 0",
               uart_rx_en, cpu_resetn, write_done, imem_we);
    end
  endtask

  task automatic test_basic();
    bq_t b;
    b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    apply_reset();
    send_bytes(b, 0, NB - 1, 3);
    cyc(1'b1, b[NB-1], 1'b0);
    n_checks++;
    if (imem_we !== 1'b1 || imem_addr !== AW'(1) || write_done !== 1'b0 || cpu_resetn !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_commit got we=%b a=%0d done=%b cpu=%b want 1 1 0 0",
               imem_we, imem_addr, write_done, cpu_resetn);
    end
    idle(1);
    n_checks++;
    if (write_done !== 1'b1 || cpu_resetn !== 1'b1 || imem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done got done=%b cpu=%b we=%b want 1 1 0", write_done, cpu_resetn, imem_we);
    end
    n_checks++;
    if (wr_a.size() != 2 || wr_a[0] !== AW'(0) || wr_d[0] !== 32'h0000_0013 ||
        wr_a[1] !== AW'(1) || wr_d[1] !== 32'h0010_0093) begin
      n_fail++;
      $display("FAIL basic_writes got n=%0d first=%h want 2 writes 00000013,00100093",
               wr_a.size(), (wr_d.size() > 0) ? wr_d[0] : 32'hx);
    end
  endtask

  task automatic test_random_images();
    bq_t b;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      gen_image(b);
      send_bytes(b, 0, NB, 5);
      idle(2);
      n_checks++;
      if (wr_a.size() != WORDS || write_done !== 1'b1 || cpu_resetn !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_done it=%0d got n=%0d done=%b cpu=%b want %0d 1 1",
                 it, wr_a.size(), write_done, cpu_resetn, WORDS);
      end
      for (int i = 0; i < WORDS && i < wr_a.size(); i++) begin
        n_checks++;
        if (wr_a[i] !== AW'(i) || wr_d[i] !== word_of(b, i)) begin
          n_fail++;
          $display("FAIL rand_write it=%0d i=%0d got a=%0d d=%h want a=%0d d=%h",
                   it, i, wr_a[i], wr_d[i], i, word_of(b, i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bq_t b;
    apply_reset();
    gen_image(b);
    send_bytes(b, 0, NB, 0);
    idle(2);
    n_checks++;
    if (wr_a.size() != WORDS || write_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_count got n=%0d done=%b want %0d 1", wr_a.size(), write_done, WORDS);
    end
    for (int i = 0; i < WORDS && i < wr_a.size(); i++) begin
      n_checks++;
      if (wr_a[i] !== AW'(i) || wr_d[i] !== word_of(b, i)) begin
        n_fail++;
        $display("FAIL b2b_write i=%0d got a=%0d d=%h want a=%0d d=%h",
                 i, wr_a[i], wr_d[i], i, word_of(b, i));
      end
    end
  endtask

  task automatic test_timeout();
    bq_t b;
    logic [7:0] k0;
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    apply_reset();
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    idle(TMO + 50);
    send_bytes(b, 0, 4, 2);
    idle(2);
    n_checks++;
    if (wr_a.size() != 1 || wr_a[0] !== AW'(0) || wr_d[0] !== 32'hDDCC_BBAA) begin
      n_fail++;
      $display("FAIL timeout_discard got n=%0d d=%h want 1 write a=0 d=ddccbbaa",
               wr_a.size(), (wr_d.size() > 0) ? wr_d[0] : 32'hx);
    end
    // A gap shorter than the timeout keeps the partial word.
    wr_a.delete();
    wr_d.delete();
    gen_image(b);
    k0 = b[0];
    cyc(1'b1, k0, 1'b0);
    idle(TMO - 5);
    send_bytes(b, 1, 4, 0);
    idle(2);
    n_checks++;
    if (wr_a.size() != 1 || wr_a[0] !== AW'(1) || wr_d[0] !== {b[3], b[2], b[1], k0} || write_done !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_keep got n=%0d d=%h done=%b want a=1 d=%h done=1",
               wr_a.size(), (wr_d.size() > 0) ? wr_d[0] : 32'hx, write_done, {b[3], b[2], b[1], k0});
    end
  endtask

  task automatic test_break();
    bq_t b1, b2;
    apply_reset();
    gen_image(b1);
    send_bytes(b1, 0, 5, 2);
    idle(1);
    cyc(1'b1, 8'h5A, 1'b1);
    idle(2);
    n_checks++;
    if (load_error !== 1'b1 || wr_a.size() != 1 || wr_d[0] !== word_of(b1, 0)) begin
      n_fail++;
      $display("FAIL break_abort got err=%b n=%0d want err=1 n=1", load_error, wr_a.size());
    end
    wr_a.delete();
    wr_d.delete();
    gen_image(b2);
    send_bytes(b2, 0, NB - 1, 3);
    n_checks++;
    if (load_error !== 1'b1) begin
      n_fail++;
      $display("FAIL break_sticky got err=%b want 1", load_error);
    end
    send_bytes(b2, NB - 1, NB, 0);
    idle(2);
    n_checks++;
    if (load_error !== 1'b0 || write_done !== 1'b1 || wr_a.size() != WORDS) begin
      n_fail++;
      $display("FAIL break_reload got err=%b done=%b n=%0d want 0 1 %0d",
               load_error, write_done, wr_a.size(), WORDS);
    end
    for (int i = 0; i < WORDS && i < wr_a.size(); i++) begin
      n_checks++;
      if (wr_a[i] !== AW'(i) || wr_d[i] !== word_of(b2, i)) begin
        n_fail++;
        $display("FAIL break_write i=%0d got a=%0d d=%h want a=%0d d=%h",
                 i, wr_a[i], wr_d[i], i, word_of(b2, i));
      end
    end
  endtask

  task automatic test_done();
    bq_t b;
    wr_a.delete();
    wr_d.delete();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    idle(2);
    n_checks++;
    if (write_done !== 1'b1 || cpu_resetn !== 1'b1 || wr_a.size() != 0) begin
      n_fail++;
      $display("FAIL done_ignore got done=%b cpu=%b n=%0d want 1 1 0", write_done, cpu_resetn, wr_a.size());
    end
    cyc(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (write_done !== 1'b0 || cpu_resetn !== 1'b0 || load_error !== 1'b0 || uart_rx_en !== 1'b1) begin
      n_fail++;
      $display("FAIL done_break got done=%b cpu=%b err=%b en=%b want 0 0 0 1",
               write_done, cpu_resetn, load_error, uart_rx_en);
    end
    gen_image(b);
    send_bytes(b, 0, NB, 2);
    idle(2);
    n_checks++;
    if (wr_a.size() != WORDS || write_done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_reload got n=%0d done=%b want %0d 1", wr_a.size(), write_done, WORDS);
    end
    for (int i = 0; i < WORDS && i < wr_a.size(); i++) begin
      n_checks++;
      if (wr_a[i] !== AW'(i) || wr_d[i] !== word_of(b, i)) begin
        n_fail++;
        $display("FAIL done_write i=%0d got a=%0d d=%h want a=%0d d=%h",
                 i, wr_a[i], wr_d[i], i, word_of(b, i));
      end
    end
  endtask

  task automatic test_reset_mid_word();
    bq_t b;
    apply_reset();
    gen_image(b);
    send_bytes(b, 0, 6, 1);
    resetn = 1'b0;
    #2;
    n_checks++;
    if ({uart_rx_en, imem_we, imem_addr, imem_wdata, cpu_resetn, write_done, load_error} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs got en=%b we=%b a=%h d=%h cpu=%b done=%b err=%b want all 0",
               uart_rx_en, imem_we, imem_addr, imem_wdata, cpu_resetn, write_done, load_error);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    wr_a.delete();
    wr_d.delete();
    idle(10);
    n_checks++;
    if (wr_a.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet got %0d writes want 0", wr_a.size());
    end
    gen_image(b);
    send_bytes(b, 0, 4, 1);
    idle(2);
    n_checks++;
    if (wr_a.size() != 1 || wr_a[0] !== AW'(0) || wr_d[0] !== word_of(b, 0)) begin
      n_fail++;
      $display("FAIL midreset_write got n=%0d a=%0d d=%h want 1 a=0 d=%h", wr_a.size(),
               (wr_a.size() > 0) ? wr_a[0] : AW'(0), (wr_d.size() > 0) ? wr_d[0] : 32'hx, word_of(b, 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_random_images();
    test_back_to_back();
    test_timeout();
    test_break();
    test_done();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
